// File: rtl/lock_keypad_ctrl.sv
// Keypad password lock: collects 4 BCD digits, compares on enter, drives unlock/alarm timers.
// Optional LOCK_CHANGE_PW_EN adds a CHANGE state (key 12 in OPEN) and a writable password register.
module lock_keypad_ctrl #(
  parameter logic [15:0] PASSWORD       = 16'h1234,
  parameter int          MAX_WRONG      = 3,
  parameter int          UNLOCK_CYCLES  = 250_000_000,
  parameter int          LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] Seg_1,
  output logic [3:0] Seg_2,
  output logic [3:0] Seg_3,
  output logic [3:0] Seg_4,
  output logic [3:0] count_Wrong,
  output logic       unlock,
  output logic       alarm
);
  localparam logic [3:0]  BLANK        = 4'hF;
  localparam logic [3:0]  K_BSP        = 4'd10;
  localparam logic [3:0]  K_ENT        = 4'd11;
  localparam logic [3:0]  MAX_W        = 4'(MAX_WRONG);
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

`ifdef LOCK_CHANGE_PW_EN
  localparam logic [3:0] K_CHG = 4'd12;
  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT, CHANGE} state_t;
`else
  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} state_t;
`endif

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  // seg_q[3] is digit 1, so the packed vector lines up with the password nibbles
  logic [3:0][3:0] seg_q, seg_d;
  logic [3:0]      cnt_q, cnt_d, cnt_inc;
  logic            unlock_q, unlock_d, alarm_q, alarm_d;
  logic [31:0]     timer_q, timer_d;
  logic [15:0]     pw;
  logic            is_digit, is_bsp, is_ent, timer_zero, editing;

`ifdef LOCK_CHANGE_PW_EN
  logic [15:0] pw_q, pw_d;
  logic        is_chg;
  assign pw     = pw_q;
  assign is_chg = key_valid && (key_code == K_CHG);
  assign editing = (state_q == ENTRY) || (state_q == CHANGE);
`else
  assign pw      = PASSWORD;
  assign editing = (state_q == ENTRY);
`endif

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_bsp     = key_valid && (key_code == K_BSP);
  assign is_ent     = key_valid && (key_code == K_ENT);
  assign timer_zero = (timer_q == '0);
  assign cnt_inc    = cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seg_d    = seg_q;
    cnt_d    = cnt_q;
    unlock_d = unlock_q;
    alarm_d  = alarm_q;
    timer_d  = timer_q;
`ifdef LOCK_CHANGE_PW_EN
    pw_d     = pw_q;
`endif
    // Digit/backspace editing is shared by ENTRY and CHANGE
    if (editing) begin
      if (is_digit && idx_q < 3'd4) begin
        seg_d[2'(3'd3 - idx_q)] = key_code;
        idx_d = idx_q + 3'd1;
      end else if (is_bsp && idx_q != 3'd0) begin
        seg_d[2'(3'd4 - idx_q)] = BLANK;
        idx_d = idx_q - 3'd1;
      end
    end
    case (state_q)
      ENTRY: begin
        if (is_ent && idx_q == 3'd4) begin
          seg_d = {4{BLANK}};
          idx_d = 3'd0;
          if (seg_q == pw) begin
            cnt_d    = 4'd0;
            unlock_d = 1'b1;
            timer_d  = UNLOCK_LOAD;
            state_d  = OPEN;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == MAX_W) begin
              alarm_d = 1'b1;
              timer_d = LOCKOUT_LOAD;
              state_d = LOCKOUT;
            end
          end
        end
      end
      OPEN: begin
        // Expiry outranks any key arriving in the same cycle
        if (timer_zero || is_ent) begin
          unlock_d = 1'b0;
          state_d  = ENTRY;
`ifdef LOCK_CHANGE_PW_EN
        end else if (is_chg) begin
          unlock_d = 1'b0;
          state_d  = CHANGE;
`endif
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      LOCKOUT: begin
        if (timer_zero) begin
          cnt_d   = 4'd0;
          alarm_d = 1'b0;
          state_d = ENTRY;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
`ifdef LOCK_CHANGE_PW_EN
      CHANGE: begin
        if (is_ent && idx_q == 3'd4) begin
          pw_d    = seg_q;
          seg_d   = {4{BLANK}};
          idx_d   = 3'd0;
          state_d = ENTRY;
        end
      end
`endif
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      idx_q    <= 3'd0;
      seg_q    <= {4{BLANK}};
      cnt_q    <= 4'd0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      timer_q  <= 32'd0;
`ifdef LOCK_CHANGE_PW_EN
      pw_q     <= PASSWORD;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      cnt_q    <= cnt_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
      timer_q  <= timer_d;
`ifdef LOCK_CHANGE_PW_EN
      pw_q     <= pw_d;
`endif
    end
  end

  assign Seg_1       = seg_q[3];
  assign Seg_2       = seg_q[2];
  assign Seg_3       = seg_q[1];
  assign Seg_4       = seg_q[0];
  assign count_Wrong = cnt_q;
  assign unlock      = unlock_q;
  assign alarm       = alarm_q;
endmodule
